// File: rtl/rf_port_arbiter.sv
// rtl/rf_port_arbiter.sv - round-robin arbiter mapping NREQ requesters onto a 1W/2R register file
// Optional read merging of same-address reads: define RF_ARB_READ_MERGE_EN.
module rf_port_arbiter #(
   parameter int DATA_WIDTH = 16,
   parameter int NREQ       = 4
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic [NREQ-1:0]            req_valid,
   input  logic [NREQ-1:0]            req_write,
   input  logic [5*NREQ-1:0]          req_addr,
   input  logic [DATA_WIDTH*NREQ-1:0] req_wdata,
   output logic [NREQ-1:0]            gnt,
   output logic [NREQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH*NREQ-1:0] rsp_data,
   output logic                       mem_wen1,
   output logic [4:0]                 mem_wad1,
   output logic [DATA_WIDTH-1:0]      mem_din,
   output logic                       mem_ren1,
   output logic [4:0]                 mem_rad1,
   output logic                       mem_ren2,
   output logic [4:0]                 mem_rad2,
   input  logic [DATA_WIDTH-1:0]      mem_dout1,
   input  logic [DATA_WIDTH-1:0]      mem_dout2,
   input  logic                       mem_collision,
   output logic                       err_collision
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [4:0]            addr_a  [NREQ];
   logic [DATA_WIDTH-1:0] wdata_a [NREQ];

   logic [PW-1:0]         ptr;
   logic [PW-1:0]         ptr_nxt;
   logic                  any_gnt;

   logic [NREQ-1:0]       gnt_c;
   logic [NREQ-1:0]       rd_gnt_c;
   logic [NREQ-1:0]       rd_port_c;
   logic                  wen_c;
   logic [4:0]            wad_c;
   logic [DATA_WIDTH-1:0] din_c;
   logic                  ren1_c;
   logic [4:0]            rad1_c;
   logic                  ren2_c;
   logic [4:0]            rad2_c;

   logic [NREQ-1:0]       rsp_valid_q;
   logic [NREQ-1:0]       rsp_port_q;
   logic                  err_q;

   int                    idx;
   logic [PW-1:0]         idx_v;
   logic [4:0]            addr;
   logic                  take;

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign addr_a[gi]  = req_addr[5*gi +: 5];
      assign wdata_a[gi] = req_wdata[DATA_WIDTH*gi +: DATA_WIDTH];
   end

   // Scan from ptr; an op is refused when its class is full or it would
   // present a read/write or read/read pair on the same address.
   always_comb begin
      gnt_c     = '0;
      rd_gnt_c  = '0;
      rd_port_c = '0;
      wen_c     = 1'b0;
      wad_c     = '0;
      din_c     = '0;
      ren1_c    = 1'b0;
      rad1_c    = '0;
      ren2_c    = 1'b0;
      rad2_c    = '0;
      any_gnt   = 1'b0;
      ptr_nxt   = ptr;
      idx       = 0;
      idx_v     = '0;
      addr      = '0;
      take      = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ)
            idx = idx - NREQ;
         idx_v = PW'(idx);
         addr  = addr_a[idx_v];
         take  = 1'b0;
         if (req_valid[idx_v]) begin
            if (req_write[idx_v]) begin
               if (!wen_c && !(ren1_c && addr == rad1_c) && !(ren2_c && addr == rad2_c)) begin
                  take  = 1'b1;
                  wen_c = 1'b1;
                  wad_c = addr;
                  din_c = wdata_a[idx_v];
               end
            end else if (!(wen_c && addr == wad_c)) begin
               if (ren1_c && addr == rad1_c) begin
`ifdef RF_ARB_READ_MERGE_EN
                  take             = 1'b1;
                  rd_gnt_c[idx_v]  = 1'b1;
                  rd_port_c[idx_v] = 1'b0;
`endif
               end else if (ren2_c && addr == rad2_c) begin
`ifdef RF_ARB_READ_MERGE_EN
                  take             = 1'b1;
                  rd_gnt_c[idx_v]  = 1'b1;
                  rd_port_c[idx_v] = 1'b1;
`endif
               end else if (!ren1_c) begin
                  take             = 1'b1;
                  ren1_c           = 1'b1;
                  rad1_c           = addr;
                  rd_gnt_c[idx_v]  = 1'b1;
                  rd_port_c[idx_v] = 1'b0;
               end else if (!ren2_c) begin
                  take             = 1'b1;
                  ren2_c           = 1'b1;
                  rad2_c           = addr;
                  rd_gnt_c[idx_v]  = 1'b1;
                  rd_port_c[idx_v] = 1'b1;
               end
            end
         end
         if (take) begin
            gnt_c[idx_v] = 1'b1;
            if (!any_gnt) begin
               any_gnt = 1'b1;
               ptr_nxt = (idx == NREQ - 1) ? '0 : PW'(idx + 1);
            end
         end
      end
   end

   assign gnt      = resetn ? gnt_c  : '0;
   assign mem_wen1 = resetn & wen_c;
   assign mem_wad1 = resetn ? wad_c  : '0;
   assign mem_din  = resetn ? din_c  : '0;
   assign mem_ren1 = resetn & ren1_c;
   assign mem_rad1 = resetn ? rad1_c : '0;
   assign mem_ren2 = resetn & ren2_c;
   assign mem_rad2 = resetn ? rad2_c : '0;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         ptr         <= '0;
         rsp_valid_q <= '0;
         rsp_port_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         if (any_gnt)
            ptr <= ptr_nxt;
         rsp_valid_q <= rd_gnt_c;
         rsp_port_q  <= rd_port_c;
         if (mem_collision)
            err_q <= 1'b1;
      end
   end

   // Tags select which registered read port feeds each requester's response.
   for (genvar gi = 0; gi < NREQ; gi++) begin : g_rsp
      assign rsp_data[DATA_WIDTH*gi +: DATA_WIDTH] =
         rsp_valid_q[gi] ? (rsp_port_q[gi] ? mem_dout2 : mem_dout1) : '0;
   end

   assign rsp_valid     = rsp_valid_q;
   assign err_collision = err_q;

endmodule

// File: tb/tb_rf_port_arbiter.sv
// tb/tb_rf_port_arbiter.sv - scoreboard bench for rf_port_arbiter with a behavioural 1W/2R register file
module tb_rf_port_arbiter;
   localparam int NREQ = 4;
   localparam int DW   = 16;

   logic              clk = 1'b0;
   logic              resetn = 1'b0;
   logic [NREQ-1:0]   req_valid = '0;
   logic [NREQ-1:0]   req_write = '0;
   logic [5*NREQ-1:0] req_addr = '0;
   logic [DW*NREQ-1:0] req_wdata = '0;
   logic [NREQ-1:0]   gnt;
   logic [NREQ-1:0]   rsp_valid;
   logic [DW*NREQ-1:0] rsp_data;
   logic              mem_wen1, mem_ren1, mem_ren2;
   logic [4:0]        mem_wad1, mem_rad1, mem_rad2;
   logic [DW-1:0]     mem_din;
   logic [DW-1:0]     mem_dout1, mem_dout2;
   logic              mem_collision;
   logic              err_collision;
   logic              force_coll = 1'b0;

   always #5 clk = ~clk;

   rf_port_arbiter #(.DATA_WIDTH(DW), .NREQ(NREQ)) dut (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .mem_wen1(mem_wen1), .mem_wad1(mem_wad1), .mem_din(mem_din),
      .mem_ren1(mem_ren1), .mem_rad1(mem_rad1),
      .mem_ren2(mem_ren2), .mem_rad2(mem_rad2),
      .mem_dout1(mem_dout1), .mem_dout2(mem_dout2),
      .mem_collision(mem_collision), .err_collision(err_collision)
   );

   // Register file environment: write and registered reads on the same edge.
   logic [DW-1:0] rf [32];
   logic          rf_loaded = 1'b0;
   always @(posedge clk) begin
      if (!rf_loaded) begin
         for (int a = 0; a < 32; a++) rf[a] <= DW'(16'h1000 + a);
         rf_loaded <= 1'b1;
         mem_dout1 <= '0;
         mem_dout2 <= '0;
      end else begin
         if (mem_wen1) rf[mem_wad1] <= mem_din;
         if (mem_ren1) mem_dout1 <= rf[mem_rad1];
         if (mem_ren2) mem_dout2 <= rf[mem_rad2];
      end
   end

   assign mem_collision = force_coll
      | (mem_wen1 & mem_ren1 & (mem_wad1 == mem_rad1))
      | (mem_wen1 & mem_ren2 & (mem_wad1 == mem_rad2))
      | (mem_ren1 & mem_ren2 & (mem_rad1 == mem_rad2));

   typedef struct {
      int                 due;
      logic [NREQ-1:0]    valid;
      logic [DW*NREQ-1:0] data;
   } rsp_t;

   rsp_t          sb[$];
   logic [DW-1:0] model_mem [32];
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   logic          mon_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard consumer: every cycle the response bus must match the queue head or be idle.
   always @(negedge clk) begin
      #2;
      if (mon_en) begin
         while (sb.size() > 0 && sb[0].due < cyc) begin
            checks++; errors++;
            $display("FAIL rsp_missing: response due cycle %0d not seen by cycle %0d", sb[0].due, cyc);
            void'(sb.pop_front());
         end
         checks++;
         if (sb.size() > 0 && sb[0].due == cyc) begin
            if (rsp_valid !== sb[0].valid || rsp_data !== sb[0].data) begin
               errors++;
               $display("FAIL rsp_match: got valid=%b data=%h expected valid=%b data=%h",
                        rsp_valid, rsp_data, sb[0].valid, sb[0].data);
            end
            void'(sb.pop_front());
         end else if (rsp_valid !== '0 || rsp_data !== '0) begin
            errors++;
            $display("FAIL rsp_idle: got valid=%b data=%h expected valid=0 data=0", rsp_valid, rsp_data);
         end
      end
   end

   task automatic set_req(input int i, input logic w, input logic [4:0] a, input logic [DW-1:0] d);
      req_valid[i]          = 1'b1;
      req_write[i]          = w;
      req_addr[5*i +: 5]    = a;
      req_wdata[DW*i +: DW] = d;
   endtask

   task automatic drop_req(input int i);
      req_valid[i] = 1'b0;
   endtask

   task automatic clear_reqs();
      req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
   endtask

   task automatic push_rsp(input logic [NREQ-1:0] v, input logic [4:0] a0, input logic [4:0] a1,
                           input logic [4:0] a2, input logic [4:0] a3);
      rsp_t e;
      logic [4:0] al [NREQ];
      al[0] = a0; al[1] = a1; al[2] = a2; al[3] = a3;
      e.due = cyc + 1;
      e.valid = v;
      e.data = '0;
      for (int i = 0; i < NREQ; i++)
         if (v[i]) e.data[DW*i +: DW] = model_mem[al[i]];
      sb.push_back(e);
   endtask

   task automatic do_reset();
      @(negedge clk); clear_reqs();
      @(negedge clk); resetn = 1'b0;
      @(negedge clk);
      @(negedge clk); resetn = 1'b1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      set_req(0, 1'b1, 5'd1, 16'h1111);
      set_req(1, 1'b0, 5'd2, 16'h0);
      set_req(2, 1'b0, 5'd3, 16'h0);
      set_req(3, 1'b1, 5'd4, 16'h4444);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk); #1;
         checks++;
         if (gnt !== '0) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
         checks++;
         if ({mem_wen1, mem_wad1, mem_din, mem_ren1, mem_rad1, mem_ren2, mem_rad2} !== '0) begin
            errors++;
            $display("FAIL reset_mem: got wen=%b wad=%0d din=%h ren1=%b rad1=%0d ren2=%b rad2=%0d expected all 0",
                     mem_wen1, mem_wad1, mem_din, mem_ren1, mem_rad1, mem_ren2, mem_rad2);
         end
         checks++;
         if (rsp_valid !== '0 || err_collision !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got rsp_valid=%b err=%b expected 0 0", rsp_valid, err_collision);
         end
      end
      clear_reqs();
      resetn = 1'b1;
      @(negedge clk); #1;
      checks++;
      if (rsp_valid !== '0 || rsp_data !== '0) begin
         errors++;
         $display("FAIL reset_release_rsp: got valid=%b data=%h expected 0", rsp_valid, rsp_data);
      end
      mon_en = 1'b1;
   endtask

   task automatic test_write_read();
      do_reset();
      @(negedge clk);
      set_req(0, 1'b1, 5'd3, 16'hBEEF);
      #1;
      checks++;
      if (gnt !== 4'b0001 || mem_wen1 !== 1'b1 || mem_wad1 !== 5'd3 || mem_din !== 16'hBEEF || mem_ren1 !== 1'b0) begin
         errors++;
         $display("FAIL wr_grant: got gnt=%b wen=%b wad=%0d din=%h ren1=%b expected 0001 1 3 beef 0",
                  gnt, mem_wen1, mem_wad1, mem_din, mem_ren1);
      end
      model_mem[3] = 16'hBEEF;
      @(negedge clk);
      clear_reqs();
      set_req(1, 1'b0, 5'd3, 16'h0);
      #1;
      checks++;
      if (gnt !== 4'b0010 || mem_ren1 !== 1'b1 || mem_rad1 !== 5'd3 || mem_wen1 !== 1'b0) begin
         errors++;
         $display("FAIL rd_after_wr_grant: got gnt=%b ren1=%b rad1=%0d wen=%b expected 0010 1 3 0",
                  gnt, mem_ren1, mem_rad1, mem_wen1);
      end
      push_rsp(4'b0010, 5'd0, 5'd3, 5'd0, 5'd0);
      @(negedge clk); clear_reqs();
   endtask

   task automatic test_rotation();
      do_reset();
      @(negedge clk);
      set_req(0, 1'b0, 5'd5, 16'h0);
      set_req(1, 1'b0, 5'd6, 16'h0);
      set_req(2, 1'b0, 5'd7, 16'h0);
      set_req(3, 1'b1, 5'd9, 16'h5A5A);
      #1;
      checks++;
      if (gnt !== 4'b1011) begin errors++; $display("FAIL rot_gnt1: got %b expected 1011", gnt); end
      checks++;
      if (mem_rad1 !== 5'd5 || mem_rad2 !== 5'd6 || mem_ren2 !== 1'b1 || mem_wad1 !== 5'd9 || mem_din !== 16'h5A5A) begin
         errors++;
         $display("FAIL rot_ports: got rad1=%0d rad2=%0d ren2=%b wad=%0d din=%h expected 5 6 1 9 5a5a",
                  mem_rad1, mem_rad2, mem_ren2, mem_wad1, mem_din);
      end
      push_rsp(4'b0011, 5'd5, 5'd6, 5'd0, 5'd0);
      model_mem[9] = 16'h5A5A;
      @(negedge clk);
      drop_req(0); drop_req(1); drop_req(3);
      #1;
      checks++;
      if (gnt !== 4'b0100 || mem_rad1 !== 5'd7 || mem_ren2 !== 1'b0 || mem_wen1 !== 1'b0) begin
         errors++;
         $display("FAIL rot_gnt2: got gnt=%b rad1=%0d ren2=%b wen=%b expected 0100 7 0 0",
                  gnt, mem_rad1, mem_ren2, mem_wen1);
      end
      push_rsp(4'b0100, 5'd0, 5'd0, 5'd7, 5'd0);
      // ptr should now be 3: requester 3 wins over 0 and 1
      @(negedge clk);
      clear_reqs();
      set_req(0, 1'b0, 5'd10, 16'h0);
      set_req(1, 1'b0, 5'd11, 16'h0);
      set_req(3, 1'b0, 5'd12, 16'h0);
      #1;
      checks++;
      if (gnt !== 4'b1001 || mem_rad1 !== 5'd12 || mem_rad2 !== 5'd10) begin
         errors++;
         $display("FAIL rot_ptr3: got gnt=%b rad1=%0d rad2=%0d expected 1001 12 10", gnt, mem_rad1, mem_rad2);
      end
      push_rsp(4'b1001, 5'd10, 5'd0, 5'd0, 5'd12);
      @(negedge clk);
      drop_req(0); drop_req(3);
      #1;
      checks++;
      if (gnt !== 4'b0010 || mem_rad1 !== 5'd11) begin
         errors++;
         $display("FAIL rot_deferred: got gnt=%b rad1=%0d expected 0010 11", gnt, mem_rad1);
      end
      push_rsp(4'b0010, 5'd0, 5'd11, 5'd0, 5'd0);
      @(negedge clk); clear_reqs();
   endtask

   task automatic test_rw_conflict();
      do_reset();
      @(negedge clk);
      set_req(0, 1'b1, 5'd4, 16'h1234);
      set_req(1, 1'b0, 5'd4, 16'h0);
      #1;
      checks++;
      if (gnt !== 4'b0001 || mem_ren1 !== 1'b0 || mem_wen1 !== 1'b1) begin
         errors++;
         $display("FAIL rw_conflict_gnt: got gnt=%b ren1=%b wen=%b expected 0001 0 1", gnt, mem_ren1, mem_wen1);
      end
      model_mem[4] = 16'h1234;
      @(negedge clk);
      drop_req(0);
      #1;
      checks++;
      if (gnt !== 4'b0010 || mem_rad1 !== 5'd4) begin
         errors++;
         $display("FAIL rw_conflict_retry: got gnt=%b rad1=%0d expected 0010 4", gnt, mem_rad1);
      end
      push_rsp(4'b0010, 5'd0, 5'd4, 5'd0, 5'd0);
      @(negedge clk); clear_reqs();
   endtask

   task automatic test_read_conflict();
      do_reset();
      @(negedge clk);
      set_req(0, 1'b0, 5'd8, 16'h0);
      set_req(2, 1'b0, 5'd8, 16'h0);
      #1;
`ifdef RF_ARB_READ_MERGE_EN
      checks++;
      if (gnt !== 4'b0101 || mem_ren2 !== 1'b0 || mem_rad1 !== 5'd8) begin
         errors++;
         $display("FAIL merge_gnt: got gnt=%b ren2=%b rad1=%0d expected 0101 0 8", gnt, mem_ren2, mem_rad1);
      end
      push_rsp(4'b0101, 5'd8, 5'd0, 5'd8, 5'd0);
      @(negedge clk); clear_reqs();
`else
      checks++;
      if (gnt !== 4'b0001 || mem_ren2 !== 1'b0 || mem_rad1 !== 5'd8) begin
         errors++;
         $display("FAIL rr_conflict_gnt: got gnt=%b ren2=%b rad1=%0d expected 0001 0 8", gnt, mem_ren2, mem_rad1);
      end
      push_rsp(4'b0001, 5'd8, 5'd0, 5'd0, 5'd0);
      @(negedge clk);
      drop_req(0);
      #1;
      checks++;
      if (gnt !== 4'b0100 || mem_rad1 !== 5'd8) begin
         errors++;
         $display("FAIL rr_conflict_retry: got gnt=%b rad1=%0d expected 0100 8", gnt, mem_rad1);
      end
      push_rsp(4'b0100, 5'd0, 5'd0, 5'd8, 5'd0);
      @(negedge clk); clear_reqs();
`endif
   endtask

   task automatic test_back_to_back();
      int p;
      int cnt [NREQ];
      int waits [NREQ];
      int max_wait;
      logic [4:0] a [NREQ];
      logic [NREQ-1:0] exp_g;
      int q;
      do_reset();
      p = 0; max_wait = 0;
      for (int i = 0; i < NREQ; i++) begin cnt[i] = 0; waits[i] = 0; end
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         for (int i = 0; i < NREQ; i++) begin
            a[i] = 5'(8 * i + (cnt[i] % 8));
            set_req(i, 1'b0, a[i], 16'h0);
         end
         #1;
         q = (p + 1) % NREQ;
         exp_g = '0;
         exp_g[p] = 1'b1;
         exp_g[q] = 1'b1;
         checks++;
         if (gnt !== exp_g || mem_rad1 !== a[p] || mem_rad2 !== a[q]) begin
            errors++;
            $display("FAIL b2b_cycle%0d: got gnt=%b rad1=%0d rad2=%0d expected %b %0d %0d",
                     c, gnt, mem_rad1, mem_rad2, exp_g, a[p], a[q]);
         end
         for (int i = 0; i < NREQ; i++) begin
            if (gnt[i] === 1'b1) waits[i] = 0;
            else begin
               waits[i]++;
               if (waits[i] > max_wait) max_wait = waits[i];
            end
         end
         push_rsp(exp_g, a[0], a[1], a[2], a[3]);
         cnt[p]++; cnt[q]++;
         p = q;
      end
      checks++;
      if (max_wait >= NREQ) begin
         errors++;
         $display("FAIL b2b_starvation: got max wait %0d cycles expected below %0d", max_wait, NREQ);
      end
      @(negedge clk); clear_reqs();
   endtask

   task automatic test_collision();
      do_reset();
      @(negedge clk); #1;
      checks++;
      if (err_collision !== 1'b0) begin errors++; $display("FAIL coll_pre: got %b expected 0", err_collision); end
      force_coll = 1'b1;
      @(negedge clk);
      force_coll = 1'b0;
      #1;
      checks++;
      if (err_collision !== 1'b1) begin errors++; $display("FAIL coll_set: got %b expected 1", err_collision); end
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (err_collision !== 1'b1) begin errors++; $display("FAIL coll_hold: got %b expected 1", err_collision); end
      do_reset();
      #1;
      checks++;
      if (err_collision !== 1'b0) begin errors++; $display("FAIL coll_clear: got %b expected 0", err_collision); end
   endtask

   initial begin
      for (int a = 0; a < 32; a++) model_mem[a] = DW'(16'h1000 + a);
      test_reset();
      test_write_read();
      test_rotation();
      test_rw_conflict();
      test_read_conflict();
      test_back_to_back();
      test_collision();
      repeat (3) @(negedge clk);
      #3;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d outstanding responses expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
